// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks pc through external instruction memory and
// hands words to decode over a valid/ready register, with redirect and fault handling.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_dout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault,
  output logic [15:0]       fetch_cnt
);

  localparam int unsigned CNT_W = 16;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_d;
  logic [INST_W-1:0] inst_d;
  logic [ADDR_W-1:0] opc_d;
  logic              fault_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              handshake;

  // Memory is always addressed from the registered pc.
  assign imem_addr = pc_q;
  assign handshake = out_valid && out_ready;

  // Next-state and datapath update; redirect wins over a normal load.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = out_valid;
    inst_d  = out_inst;
    opc_d   = out_pc;
    fault_d = fault;
    cnt_d   = fetch_cnt;

    if (state_q != HALT) begin
      if (handshake && (fetch_cnt != {CNT_W{1'b1}})) begin
        cnt_d = fetch_cnt + CNT_W'(1);
      end
      state_d = run ? RUN : IDLE;

      if (redirect_valid) begin
        valid_d = 1'b0;
        if (redirect_pc[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          pc_d = redirect_pc;
        end
      end else if (state_q == RUN) begin
        if (!out_valid || out_ready) begin
          inst_d  = imem_dout;
          opc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(PC_STEP);
        end
      end else if (handshake) begin
        valid_d = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= ADDR_W'(RESET_PC);
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_valid <= valid_d;
      out_inst  <= inst_d;
      out_pc    <= opc_d;
      fault     <= fault_d;
      fetch_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a behavioural fetch model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [4:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [4:0]  out_pc;
  logic        fault;
  logic [15:0] fetch_cnt;

  logic [31:0] mem [8];

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int          m_pc;
  bit          m_running;
  bit          m_halted;
  bit          m_valid;
  logic [31:0] m_inst;
  int          m_opc;
  bit          m_fault;
  int          m_cnt;

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_addr[4:2]];

  fetch_ctrl #(.ADDR_W(5), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock from the current inputs.
  task automatic model_edge();
    bit hs;
    if (!rst_n) begin
      m_pc = 0; m_running = 0; m_halted = 0; m_valid = 0;
      m_inst = '0; m_opc = 0; m_fault = 0; m_cnt = 0;
    end else if (!m_halted) begin
      hs = m_valid && out_ready;
      if (hs && m_cnt < 65535) m_cnt++;
      if (redirect_valid) begin
        m_valid = 0;
        if (redirect_pc % 4 != 0) begin
          m_fault = 1; m_halted = 1;
        end else begin
          m_pc = int'(redirect_pc);
        end
      end else if (m_running) begin
        if (!m_valid || out_ready) begin
          m_inst  = mem[m_pc / 4];
          m_opc   = m_pc;
          m_valid = 1;
          m_pc    = (m_pc + 4) % 32;
        end
      end else if (hs) begin
        m_valid = 0;
      end
      if (!m_halted) m_running = run;
    end
  endtask

  // One clock: update model, let DUT take the edge, compare away from the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_inst",  out_inst, m_inst);
    chk("out_pc",    32'(out_pc), 32'(m_opc));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("fault",     32'(fault), 32'(m_fault));
    chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    logic [31:0] held;
    mem[0] = 32'h01000413; mem[1] = 32'h10100493; mem[2] = 32'h00848933; mem[3] = 32'h00000000;
    mem[4] = 32'hA5A50010; mem[5] = 32'h5A5A0014; mem[6] = 32'hC3C30018; mem[7] = 32'h3C3C001C;

    // reset state
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(fetch_cnt), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // streaming fetch with decode always ready
    run = 1'b1; out_ready = 1'b1;
    step(); step();
    chk("s0_inst", out_inst, 32'h01000413); chk("s0_pc", 32'(out_pc), 32'd0);
    step();
    chk("s1_inst", out_inst, 32'h10100493); chk("s1_pc", 32'(out_pc), 32'd4);
    step();
    chk("s2_inst", out_inst, 32'h00848933); chk("s2_pc", 32'(out_pc), 32'd8);
    step();
    chk("s_cnt3", 32'(fetch_cnt), 32'd3);

    // backpressure holds the output register
    do_reset();
    run = 1'b1; out_ready = 1'b0;
    step(); step();
    held = out_inst;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_inst", out_inst, 32'h01000413);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_pc", 32'(out_pc), 32'd0);
      chk("bp_addr", 32'(imem_addr), 32'd4);
      chk("bp_cnt", 32'(fetch_cnt), 32'd0);
    end
    chk("bp_held", out_inst, held);

    // aligned redirect to 8: bubble then target; handshake in redirect cycle counts
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd8;
    step();
    redirect_valid = 1'b0;
    chk("rd_bubble", 32'(out_valid), 32'd0);
    chk("rd_cnt", 32'(fetch_cnt), 32'd1);
    step();
    chk("rd_inst", out_inst, 32'h00848933); chk("rd_pc", 32'(out_pc), 32'd8);

    // handshake and redirect together
    c = int'(fetch_cnt);
    redirect_valid = 1'b1; redirect_pc = 5'd0;
    step();
    redirect_valid = 1'b0;
    chk("hr_cnt", 32'(fetch_cnt), 32'(c + 1));
    step();
    chk("hr_valid", 32'(out_valid), 32'd1);
    chk("hr_inst", out_inst, 32'h01000413); chk("hr_pc", 32'(out_pc), 32'd0);

    // pc wrap from 28
    redirect_valid = 1'b1; redirect_pc = 5'd28;
    step();
    redirect_valid = 1'b0;
    step(); chk("wr_pc28", 32'(out_pc), 32'd28);
    step(); chk("wr_pc0", 32'(out_pc), 32'd0); chk("wr_inst0", out_inst, 32'h01000413);
    step(); chk("wr_pc4", 32'(out_pc), 32'd4);

    // misaligned redirect halts; later redirects ignored; reset recovers
    redirect_valid = 1'b1; redirect_pc = 5'd6;
    step();
    c = int'(imem_addr);
    chk("ma_fault", 32'(fault), 32'd1); chk("ma_valid", 32'(out_valid), 32'd0);
    redirect_pc = 5'd0;
    step(); step();
    redirect_valid = 1'b0;
    chk("ma_sticky", 32'(fault), 32'd1); chk("ma_hold_addr", 32'(imem_addr), 32'(c));
    chk("ma_valid2", 32'(out_valid), 32'd0);
    do_reset();
    chk("ma_rst_fault", 32'(fault), 32'd0); chk("ma_rst_cnt", 32'(fetch_cnt), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      run            = ($urandom_range(0, 9) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = 5'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 19) == 0) redirect_pc = 5'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, byte-address width of instruction memory.
REQ-002 SHALL have parameter RESET_PC, default 0, fetch address loaded at reset; multiple of 4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port run  input  1  fetch enable.
REQ-006 SHALL have port imem_addr  output  ADDR_W  byte address to instruction memory.
REQ-007 SHALL have port imem_dout  input  32  little-endian word, combinational from imem_addr.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  ADDR_W  redirect target address.
REQ-010 SHALL have port out_valid  output  1  out_inst/out_pc hold a fetched instruction.
REQ-011 SHALL have port out_ready  input  1  decode accepts the instruction.
REQ-012 SHALL have port out_inst  output  32  fetched instruction word.
REQ-013 SHALL have port out_pc  output  ADDR_W  address of out_inst.
REQ-014 SHALL have port fault  output  1  sticky misaligned-redirect flag.
REQ-015 SHALL have port fetch_cnt  output  16  count of accepted instructions, saturating.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT: IDLE->RUN when run=1; RUN->IDLE when run=0; any state->HALT on a misaligned redirect; HALT exits only by reset.
REQ-017 SHALL drive imem_addr from the internal pc register only, never combinationally from redirect_pc.
REQ-018 SHALL, in RUN with no redirect, load the output register when out_valid=0 or (out_valid and out_ready): out_inst<=imem_dout, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-019 SHALL wrap pc modulo 2^ADDR_W, so that pc 28 advances to 0 for ADDR_W=5.
REQ-020 SHALL hold out_valid, out_inst and out_pc stable while out_valid=1 and out_ready=0.
REQ-021 SHALL clear out_valid when a handshake completes in IDLE, and SHALL load no new instruction in IDLE.
REQ-022 SHALL, on an aligned redirect (redirect_pc[1:0]=0) in IDLE or RUN, set pc<=redirect_pc and out_valid<=0 in the same edge, discarding any unaccepted instruction.
REQ-023 SHALL present the target instruction with out_valid=1 exactly 2 cycles after the redirect cycle when in RUN and no further redirect arrives.
REQ-024 SHALL give redirect priority over a normal load; a handshake in the redirect cycle still counts as accepted.
REQ-025 SHALL, on a redirect with redirect_pc[1:0]!=0, set fault=1, out_valid=0, enter HALT and leave pc unchanged.
REQ-026 SHALL increment fetch_cnt on each out_valid&&out_ready cycle and saturate at 16'hFFFF.
REQ-027 SHALL ignore redirect_valid, run and out_ready in HALT, with out_valid held 0.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set state=IDLE, pc=RESET_PC, out_valid=0, out_inst=0, out_pc=0, fault=0, fetch_cnt=0.
REQ-029 SHALL let reset override every other input in the same edge, including mid-handshake and in HALT.

Structure
REQ-030 SHALL take the state enum, INST_W=32 and PC_STEP=4 from shared package fetch_pkg.
REQ-031 SHALL be a single module with no sub-modules; the instruction memory sits outside fetch_ctrl and connects through imem_addr/imem_dout.

Verification
The bench connects an instruction memory loaded with 0x0:01000413, 0x4:10100493, 0x8:00848933, 0xC:00000000.
REQ-032 SHALL verify: reset, run=1, out_ready=1 -> out_inst 01000413@0, 10100493@4, 00848933@8 on consecutive cycles; fetch_cnt=3.
REQ-033 SHALL verify: out_ready=0 for 5 cycles with out_valid=1 -> out_inst=01000413 and out_pc=0 stable; fetch_cnt unchanged; pc=4.
REQ-034 SHALL verify: redirect_valid=1, redirect_pc=8 at cycle N -> out_valid=0 at N+1; out_inst=00848933, out_pc=8 at N+2.
REQ-035 SHALL verify: redirect_pc=6 -> fault=1, out_valid=0, HALT; later redirect_pc=0 is ignored; rst_n=0 clears fault and fetch_cnt.
REQ-036 SHALL verify: free-run from pc=28 -> out_pc sequence 28, 0, 4; the 0x0 word reappears as 01000413.
REQ-037 SHALL verify: handshake and redirect in the same cycle -> fetch_cnt+1, and the next valid output is the redirect target.
